imm_ext_pipe: RTL

Parametrised, registered immediate-extension stage that sits between the decode unit and the ALU/branch operand muxes. It widens an IN_W-bit instruction constant to OUT_W bits in one of four modes: zero-extend, sign-extend, sign-extend-and-shift (branch offsets), or upper-place (load-upper). Results pass through a 2-entry output buffer with valid/ready handshakes, so decode is decoupled from downstream stalls. The block also flags shift overflow and keeps a saturating count of overflow events.

---
 rtl/imm_ext_pipe.sv | 135 +++++++++++++
 1 files changed

// File: rtl/imm_ext_pipe.sv
// Registered immediate-extension stage: widens an IN_W constant to OUT_W bits
// (zero / sign / sign+shift / upper-place) behind a 2-entry valid/ready buffer.
module imm_ext_pipe #(
    parameter int IN_W  = 6,
    parameter int OUT_W = 16,
    parameter int SHIFT = 1,
    parameter int TAG_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             clr_count
);

    localparam int WW = OUT_W + SHIFT;

    logic [OUT_W-1:0] ext_imm;
    logic             ext_err;
    logic [WW-1:0]    shl;

    logic [1:0]       cnt_q, cnt_d;
    logic [OUT_W-1:0] imm0_q, imm0_d, imm1_q, imm1_d;
    logic [TAG_W-1:0] tag0_q, tag0_d, tag1_q, tag1_d;
    logic             err0_q, err0_d, err1_q, err1_d;
    logic [CNT_W-1:0] ovf_q, ovf_d;
    logic             push, pop;

    // Mode 10 is computed SHIFT bits wider so the discarded bits and the new
    // MSB can be checked for agreement.
    always_comb begin
        ext_imm = '0;
        ext_err = 1'b0;
        shl     = WW'($signed(in_imm)) << SHIFT;
        case (in_mode)
            2'b00: ext_imm = OUT_W'(in_imm);
            2'b01: ext_imm = OUT_W'($signed(in_imm));
            2'b10: begin
                ext_imm = shl[OUT_W-1:0];
                ext_err = !((&shl[WW-1:OUT_W-1]) || !(|shl[WW-1:OUT_W-1]));
            end
            default: ext_imm = OUT_W'(in_imm) << (OUT_W - IN_W);
        endcase
    end

    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Entry 0 is always the head and drives out_* directly.
    always_comb begin
        cnt_d  = cnt_q;
        imm0_d = imm0_q;
        tag0_d = tag0_q;
        err0_d = err0_q;
        imm1_d = imm1_q;
        tag1_d = tag1_q;
        err1_d = err1_q;
        case ({push, pop})
            2'b10: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd0) begin
                    imm0_d = ext_imm;
                    tag0_d = in_tag;
                    err0_d = ext_err;
                end else begin
                    imm1_d = ext_imm;
                    tag1_d = in_tag;
                    err1_d = ext_err;
                end
            end
            2'b01: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd2) begin
                    imm0_d = imm1_q;
                    tag0_d = tag1_q;
                    err0_d = err1_q;
                end
            end
            2'b11: begin
                imm0_d = ext_imm;
                tag0_d = in_tag;
                err0_d = ext_err;
            end
            default: ;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (clr_count)
            ovf_d = '0;
        else if (push && ext_err && !(&ovf_q))
            ovf_d = ovf_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            imm0_q <= '0;
            tag0_q <= '0;
            err0_q <= 1'b0;
            imm1_q <= '0;
            tag1_q <= '0;
            err1_q <= 1'b0;
            ovf_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            imm0_q <= imm0_d;
            tag0_q <= tag0_d;
            err0_q <= err0_d;
            imm1_q <= imm1_d;
            tag1_q <= tag1_d;
            err1_q <= err1_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out_imm   = imm0_q;
    assign out_tag   = tag0_q;
    assign out_err   = err0_q;
    assign ovf_count = ovf_q;

endmodule
